clock_period_meter: RTL
=======================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the period and count registers in bits.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the number of clock_in cycles without an edge that declares the measured signal stalled; the legal range SHALL be 2 to 2^CNT_W-1.
REQ-003 clock_in  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  1  asynchronous slow clock to be measured, e.g. a divider output.
REQ-006 period  output  CNT_W  last measured rising-edge-to-rising-edge interval, in clock_in cycles.
REQ-007 period_valid  output  1  one-cycle pulse when period is updated.
REQ-008 timeout  output  1  level; high while sig_in is stalled.
REQ-009 high_time  output  CNT_W  last measured high-phase length in clock_in cycles; present only with DUTY_MEAS_EN.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer and then a registered rising/falling-edge detector; a sig_in rise SHALL be detected 3 clock_in cycles later.
REQ-011 FSM states SHALL be IDLE, MEASURE and TIMEOUT; the reset state SHALL be IDLE.
REQ-012 IDLE: on a detected rise, cnt SHALL load 1, the FSM SHALL go to MEASURE, and period_valid SHALL stay low.
REQ-013 MEASURE: cnt SHALL increment by 1 each cycle with no edge; on a detected rise, period SHALL load cnt, period_valid SHALL pulse for exactly 1 cycle, and cnt SHALL reload 1.
REQ-014 Rises N cycles apart SHALL report period = N; period_valid SHALL assert 1 cycle after the detected rise.
REQ-015 MEASURE: if cnt == TIMEOUT_CYCLES and no rise is detected, the FSM SHALL go to TIMEOUT, timeout SHALL go high, and period SHALL hold its last value.
REQ-016 A rise detected in the same cycle as the timeout condition SHALL win: the measurement completes normally and there is no timeout.
REQ-017 TIMEOUT: cnt SHALL hold; on a detected rise, cnt SHALL load 1, timeout SHALL clear next cycle, the FSM SHALL go to MEASURE, and there SHALL be no period_valid pulse, so the first interval after a stall is discarded.
REQ-018 cnt SHALL never wrap; TIMEOUT_CYCLES bounds it.
REQ-019 Falling edges SHALL NOT affect period, cnt or state.

Reset
REQ-020 While reset is high: synchronizer flops, edge detector, cnt, period, period_valid, timeout and high_time SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-021 Reset asserted mid-measurement SHALL discard the partial count; after release, the first rise SHALL only restart measurement, with no valid pulse.

Configuration
REQ-022 With DUTY_MEAS_EN defined: a high counter SHALL load 1 on a rise and increment while the synced signal is high; on a fall in MEASURE it SHALL latch into high_time, which updates independently of period_valid; the high counter SHALL saturate at TIMEOUT_CYCLES.
REQ-023 Without DUTY_MEAS_EN: no high_time port and no high counter logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-024 Package clock_meter_pkg SHALL hold the FSM state typedef (IDLE, MEASURE, TIMEOUT) and the default CNT_W and TIMEOUT_CYCLES constants.
REQ-025 Synchronizer plus edge detector SHALL be sub-module sync_edge_detect (ports clock_in, reset, d, rise, fall), instantiated once.

Verification
REQ-026 sig_in toggles every 5 cycles (divide-by-10) -> first rise gives no valid; every later rise gives period = 10, one valid pulse per period.
REQ-027 Divide-by-10, 50% duty, DUTY_MEAS_EN defined -> high_time = 5 after each fall.
REQ-028 TIMEOUT_CYCLES = 20, sig_in held low after one period of 10 -> timeout high exactly 20 cycles after the last detected rise; period stays 10.
REQ-029 From TIMEOUT, resume divide-by-6 -> first rise clears timeout with no valid; next rise gives period = 6.
REQ-030 Pulse reset for 1 cycle mid-period of a divide-by-10 stream -> all outputs 0; first post-reset rise gives no valid; second gives period = 10.
REQ-031 TIMEOUT_CYCLES = 10 with rises exactly 10 apart -> timeout never asserts; period = 10 every edge.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared constants and FSM state encoding for the clock period meter.
package clock_meter_pkg;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    MEASURE = S_MEASURE,
    TIMEOUT = S_TIMEOUT
  } meter_state_t;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/clock_period_meter.sv
// Measures the rise-to-rise period of an asynchronous slow signal in clock_in cycles.
// Optional high-phase measurement is enabled by defining DUTY_MEAS_EN.
//
// state   | meaning
// IDLE    | no rise seen since reset; waiting to start
// MEASURE | counting cycles since the last rise
// TIMEOUT | signal stalled; count held until the next rise
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
`ifdef DUTY_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  meter_state_t     state;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  // A rise always takes priority over the timeout compare, so rises exactly
  // TIMEOUT_CYCLES apart still complete a measurement.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= ONE;
          end else if (cnt == TO_LIM) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        TIMEOUT: begin
          if (rise) begin
            cnt     <= ONE;
            timeout <= 1'b0;
            state   <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_cnt;
  logic             high_active;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      high_cnt    <= '0;
      high_active <= 1'b0;
      high_time   <= '0;
    end else if (rise) begin
      high_cnt    <= ONE;
      high_active <= 1'b1;
    end else if (fall) begin
      high_active <= 1'b0;
      if (state == MEASURE) high_time <= high_cnt;
    end else if (high_active && (high_cnt != TO_LIM)) begin
      high_cnt <= high_cnt + ONE;
    end
  end
`else
  logic unused_fall;
  assign unused_fall = fall;
`endif

endmodule
